// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back path.
//   REG_ZERO  : hard-wired zero register; writes to it are dropped.
//   ADDR_W    : register-file address width.
//   N_DEFAULT : default data-bus width.
//   wb_req_t  : one write request {da, d} at the default data width.
package wb_pkg;

    localparam int                ADDR_W    = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO  = 5'd31;
    localparam int                N_DEFAULT = 64;

    typedef struct packed {
        logic [ADDR_W-1:0]    da;
        logic [N_DEFAULT-1:0] d;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Holding buffer for accepted memory-load write requests.
// DEPTH-entry synchronous FIFO (DEPTH a power of two, so pointers wrap naturally).
// Ports:
//   clock, reset (sync, active-low)
//   push, din        : write one entry (caller guarantees not full)
//   pop, dout        : dout is the head entry; pop removes it (caller guarantees not empty)
//   full, empty, count
module wb_fifo #(
    parameter  int W     = 69,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/write_back_arbiter.sv
// Arbitrates ALU results and buffered memory loads onto the single
// register-file write port.
// Ports:
//   clock, reset (sync, active-low)
//   alu_valid/alu_ready/alu_da/alu_d : ALU write request (never buffered)
//   mem_valid/mem_ready/mem_da/mem_d : load write request (buffered in wb_fifo)
//   D, DA, write                     : registered register-file write port
//   busy                             : buffer non-empty or write high
//   SA, SB, fwd_a_hit, fwd_b_hit, fwd_a, fwd_b : bypass of the write port,
//                                      only when WB_FORWARD_EN is defined
// ALU has priority, except that a waiting load is forced through after
// STARVE_MAX consecutive ALU wins. Writes to REG_ZERO are consumed but
// leave write low.
module write_back_arbiter
    import wb_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_da,
    input  logic [N-1:0]      alu_d,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_da,
    input  logic [N-1:0]      mem_d,
    output logic [N-1:0]      D,
    output logic [ADDR_W-1:0] DA,
    output logic              write,
    output logic              busy
`ifdef WB_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [N-1:0]      fwd_a,
    output logic [N-1:0]      fwd_b
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int FW = ADDR_W + N;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [FW-1:0]     fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_push_s;
    logic [ADDR_W-1:0] head_da_s;
    logic [N-1:0]      head_d_s;

    logic              sel_alu_s;
    logic              sel_mem_s;
    logic              alu_ready_s;

    logic [SW-1:0]     starve_r;
    logic [N-1:0]      d_r;
    logic [ADDR_W-1:0] da_r;
    logic              write_r;

    assign mem_ready   = reset && !fifo_full_s;
    assign fifo_push_s = mem_valid && mem_ready;
    assign head_da_s   = fifo_dout_s[N +: ADDR_W];
    assign head_d_s    = fifo_dout_s[N-1:0];

    wb_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push_s),
        .din   ({mem_da, mem_d}),
        .pop   (sel_mem_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Issue selection: forced load, else ALU, else load, else idle.
    always_comb begin
        sel_alu_s   = 1'b0;
        sel_mem_s   = 1'b0;
        alu_ready_s = reset;
        if ((starve_r == SW'(STARVE_MAX)) && !fifo_empty_s) begin
            sel_mem_s   = reset;
            alu_ready_s = 1'b0;
        end else if (alu_valid) begin
            sel_alu_s = reset;
        end else if (!fifo_empty_s) begin
            sel_mem_s = reset;
        end else begin
            sel_alu_s = 1'b0;
        end
    end

    assign alu_ready = alu_ready_s;

    // Registered write port and starvation counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            write_r  <= 1'b0;
            d_r      <= {N{1'b0}};
            da_r     <= REG_ZERO;
            starve_r <= {SW{1'b0}};
        end else if (sel_alu_s) begin
            write_r <= (alu_da != REG_ZERO);
            d_r     <= alu_d;
            da_r    <= alu_da;
            // Only ALU wins over a waiting load count towards starvation.
            if (fifo_empty_s) begin
                starve_r <= {SW{1'b0}};
            end else if (starve_r == SW'(STARVE_MAX)) begin
                starve_r <= starve_r;
            end else begin
                starve_r <= starve_r + SW'(1);
            end
        end else if (sel_mem_s) begin
            write_r  <= (head_da_s != REG_ZERO);
            d_r      <= head_d_s;
            da_r     <= head_da_s;
            starve_r <= {SW{1'b0}};
        end else begin
            write_r  <= 1'b0;
            starve_r <= {SW{1'b0}};
        end
    end

    assign D     = d_r;
    assign DA    = da_r;
    assign write = write_r;
    assign busy  = (fifo_count_s != {CW{1'b0}}) || write_r;

`ifdef WB_FORWARD_EN
    assign fwd_a_hit = write_r && (da_r == SA) && (SA != REG_ZERO);
    assign fwd_b_hit = write_r && (da_r == SB) && (SB != REG_ZERO);
    assign fwd_a     = d_r;
    assign fwd_b     = d_r;
`endif

endmodule

// File: tb/tb_write_back_arbiter.sv
// Self-checking bench for write_back_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_write_back_arbiter;
    import wb_pkg::*;

    localparam int N          = 64;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]        alu_da, mem_da, DA;
    logic [N-1:0]      alu_d, mem_d, D;
    logic              write, busy;
`ifdef WB_FORWARD_EN
    logic [4:0]        SA, SB;
    logic              fwd_a_hit, fwd_b_hit;
    logic [N-1:0]      fwd_a, fwd_b;
`endif

    always #5 clock = ~clock;

    write_back_arbiter #(.N(N), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_da(alu_da), .alu_d(alu_d),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_da(mem_da), .mem_d(mem_d),
        .D(D), .DA(DA), .write(write), .busy(busy)
`ifdef WB_FORWARD_EN
        , .SA(SA), .SB(SB), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: pending loads in a queue, starvation as a plain count.
    wb_req_t      m_q[$];
    int           m_starve = 0;
    logic         m_write  = 1'b0;
    logic [N-1:0] m_d      = {N{1'b0}};
    logic [4:0]   m_da     = 5'd31;
    logic         m_alu_acc = 1'b0;
    logic         m_mem_acc = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic model_issue(input logic [4:0] da, input logic [N-1:0] d);
        m_da    = da;
        m_d     = d;
        m_write = (da != 5'd31);
    endtask

    // One clock: check handshake outputs, advance model at the edge, check write port.
    task automatic do_cycle();
        logic    exp_ar, exp_mr, had;
        wb_req_t r;
        exp_ar = reset && !((m_starve == STARVE_MAX) && (m_q.size() > 0));
        exp_mr = reset && (m_q.size() < DEPTH);
        #1;
        check_val("alu_ready", alu_ready, exp_ar);
        check_val("mem_ready", mem_ready, exp_mr);
        @(posedge clock);
        if (!reset) begin
            m_q.delete();
            m_starve  = 0;
            m_write   = 1'b0;
            m_d       = {N{1'b0}};
            m_da      = 5'd31;
            m_alu_acc = 1'b0;
            m_mem_acc = 1'b0;
        end else begin
            m_alu_acc = alu_valid && exp_ar;
            m_mem_acc = mem_valid && exp_mr;
            had = (m_q.size() > 0);
            if (m_alu_acc) begin
                model_issue(alu_da, alu_d);
                m_starve = had ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
            end else if (had) begin
                r = m_q.pop_front();
                model_issue(r.da, r.d);
                m_starve = 0;
            end else begin
                m_write  = 1'b0;
                m_starve = 0;
            end
            if (m_mem_acc) begin
                r.da = mem_da;
                r.d  = mem_d;
                m_q.push_back(r);
            end
        end
        #1;
        check_val("write", write, m_write);
        check_val("DA", DA, m_da);
        check_val("D", D, m_d);
        check_val("busy", busy, (m_q.size() > 0) || m_write);
`ifdef WB_FORWARD_EN
        check_val("fwd_a_hit", fwd_a_hit, m_write && (m_da == SA) && (SA != 5'd31));
        check_val("fwd_b_hit", fwd_b_hit, m_write && (m_da == SB) && (SB != 5'd31));
        if (m_write && (m_da == SA)) begin
            check_val("fwd_a", fwd_a, m_d);
        end else begin
            check_val("fwd_a_idle_hit", fwd_a_hit, 1'b0 || (m_write && (m_da == SA) && (SA != 5'd31)));
        end
`endif
    endtask

    initial begin
        int         seq[8];
        int         exp_seq[8];
        int         nseq;
        int         loads_sent;
        logic [4:0] load_seen[$];

        reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        alu_da = 5'd0; alu_d = {N{1'b0}}; mem_da = 5'd0; mem_d = {N{1'b0}};
`ifdef WB_FORWARD_EN
        SA = 5'd31; SB = 5'd0;
`endif
        // Reset state
        do_cycle(); do_cycle();
        check_val("rst_write", write, 1'b0);
        check_val("rst_DA", DA, 5'd31);
        check_val("rst_D", D, 64'd0);
        reset = 1'b1;

        // ALU-only single write, then write drops
        alu_valid = 1'b1; alu_da = 5'd3; alu_d = 64'h1234;
        do_cycle();
        alu_valid = 1'b0;
        check_val("alu_write", write, 1'b1);
        check_val("alu_DA", DA, 5'd3);
        check_val("alu_D", D, 64'h1234);
        do_cycle();
        check_val("alu_write_drop", write, 1'b0);
        check_val("alu_D_hold", D, 64'h1234);

        // Load-only: two-cycle latency
        mem_valid = 1'b1; mem_da = 5'd5; mem_d = 64'hAA;
        do_cycle();
        mem_valid = 1'b0;
        check_val("load_lat1_write", write, 1'b0);
        do_cycle();
        check_val("load_write", write, 1'b1);
        check_val("load_DA", DA, 5'd5);
        check_val("load_D", D, 64'hAA);
        do_cycle();

        // Starvation: ALU streams DA 1,2,3..., one load DA=9
        alu_valid = 1'b1; alu_da = 5'd1; alu_d = 64'h100;
        mem_valid = 1'b1; mem_da = 5'd9; mem_d = 64'h99;
        exp_seq = '{1, 2, 3, 4, 9, 5, 6, 7};
        nseq = 0;
        for (int i = 0; i < 8; i++) begin
            do_cycle();
            if (write && nseq < 8) begin
                seq[nseq] = int'(DA);
                nseq++;
            end
            if (m_mem_acc) mem_valid = 1'b0;
            if (m_alu_acc) begin
                alu_da = alu_da + 5'd1;
                alu_d  = alu_d + 64'd1;
            end
        end
        check_val("starve_count", nseq, 8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("starve_seq%0d", i), seq[i], exp_seq[i]);
        end
        alu_valid = 1'b0;
        do_cycle(); do_cycle();

        // Full buffer: ALU held, three loads offered back to back
        alu_valid = 1'b1; alu_da = 5'd1;
        mem_valid = 1'b1; mem_da = 5'd20; mem_d = 64'h2000;
        loads_sent = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 16) alu_valid = 1'b0;
            do_cycle();
            if (write && DA >= 5'd20 && DA <= 5'd22) load_seen.push_back(DA);
            if (m_alu_acc) alu_da = (alu_da % 5'd15) + 5'd1;
            if (m_mem_acc) begin
                loads_sent++;
                if (loads_sent == 3) begin
                    mem_valid = 1'b0;
                end else begin
                    mem_da = mem_da + 5'd1;
                    mem_d  = mem_d + 64'd1;
                end
            end
        end
        check_val("full_loads_sent", loads_sent, 3);
        check_val("full_loads_seen", load_seen.size(), 3);
        for (int i = 0; i < 3 && i < load_seen.size(); i++) begin
            check_val($sformatf("full_order%0d", i), load_seen[i], 5'd20 + 5'(i));
        end

        // Zero register: consumed, no write
        alu_valid = 1'b1; alu_da = 5'd31; alu_d = 64'hFFFF;
`ifdef WB_FORWARD_EN
        SA = 5'd31;
`endif
        do_cycle();
        alu_valid = 1'b0;
        check_val("zero_write", write, 1'b0);
        check_val("zero_DA", DA, 5'd31);
        check_val("zero_D", D, 64'hFFFF);
        do_cycle();

        // Reset with two loads buffered behind a streaming ALU
        alu_valid = 1'b1; alu_da = 5'd1; alu_d = 64'h500;
        mem_valid = 1'b1; mem_da = 5'd12; mem_d = 64'hC0;
        for (int i = 0; i < 2; i++) begin
            do_cycle();
            if (m_alu_acc) alu_da = alu_da + 5'd1;
            if (m_mem_acc) begin
                mem_da = mem_da + 5'd1;
                mem_d  = mem_d + 64'd1;
            end
        end
        check_val("pre_rst_busy", busy, 1'b1);
        reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        do_cycle();
        check_val("midrst_write", write, 1'b0);
        check_val("midrst_DA", DA, 5'd31);
        check_val("midrst_D", D, 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            check_val("post_rst_nowrite", write, 1'b0);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if (!alu_valid || m_alu_acc) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_da    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                alu_d     = {$urandom, $urandom};
            end
            if (!mem_valid || m_mem_acc) begin
                mem_valid = ($urandom_range(0, 1) != 0);
                mem_da    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                mem_d     = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 99) != 0);
`ifdef WB_FORWARD_EN
            SA = 5'($urandom_range(0, 31));
            SB = m_da;
`endif
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/write_back_arbiter.md
WRITE_BACK_ARBITER -- requirements
Module: write_back_arbiter

Interface
REQ-001 Parameter N, default 64, data width of every data bus.
REQ-002 Parameter DEPTH, default 2, memory-load holding buffer entries (power of two, >=2).
REQ-003 Parameter STARVE_MAX, default 3, consecutive ALU wins tolerated while a load waits (>=1).
REQ-004 clock  in  1  posedge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 alu_valid in 1, alu_ready out 1, alu_da in 5, alu_d in N  ALU result write request.
REQ-007 mem_valid in 1, mem_ready out 1, mem_da in 5, mem_d in N  memory-load write request.
REQ-008 D  out  N  register-file data input.
REQ-009 DA  out  5  register-file destination address.
REQ-010 write  out  1  register-file write enable.
REQ-011 busy  out  1  buffer non-empty or write high.
REQ-012 SA in 5, SB in 5, fwd_a_hit out 1, fwd_b_hit out 1, fwd_a out N, fwd_b out N  bypass interface, present only with WB_FORWARD_EN.

Function
REQ-013 Handshake completes on valid&&ready at posedge; a valid source holds da/d stable until accepted.
REQ-014 mem_ready shall equal (count<DEPTH) with reset high; no combinational dependency on mem_valid.
REQ-015 Accepted loads enter the FIFO buffer; they issue in acceptance order; minimum load latency 2 cycles (accept -> buffer -> issue).
REQ-016 One write issued per cycle max; issued D/DA/write registered, visible the cycle after selection.
REQ-017 Selection priority: (a) starve_cnt==STARVE_MAX and buffer non-empty -> buffer head, alu_ready=0; (b) else alu_valid -> ALU, alu_ready=1; (c) else buffer non-empty -> head; (d) else write=0.
REQ-018 alu_ready shall be 1 whenever reset high and case (a) not active, regardless of alu_valid.
REQ-019 starve_cnt increments (saturating at STARVE_MAX) when ALU issues while buffer non-empty; clears when buffer issues or buffer empty.
REQ-020 Push and pop in the same cycle leave count unchanged; push when count==DEPTH cannot occur.
REQ-021 Issued request with DA==31 consumed normally but drives write=0 (D/DA still updated); counts as an issue for starvation.
REQ-022 No hazard ordering between ALU and load to the same register; issue order alone defines final value.
REQ-023 write deasserts the cycle after no selection; D/DA hold last value when write=0.

Reset
REQ-024 While reset==0 at posedge: write=0, D=0, DA=31, count=0, starve_cnt=0, FIFO pointers 0.
REQ-025 While reset==0: alu_ready=0, mem_ready=0; in-flight and buffered requests discarded; no write in first cycle after release.

Configuration
REQ-026 WB_FORWARD_EN defined: fwd_a_hit = write && DA==SA && SA!=31, fwd_a = D (same for B), combinational from registered outputs.
REQ-027 WB_FORWARD_EN undefined: SA, SB, fwd_* ports and logic absent; all other behaviour identical.

Structure
REQ-028 Shared package wb_pkg holds REG_ZERO=5'd31, ADDR_W=5, default N=64, and the write-request struct {da, d}.
REQ-029 Holding buffer is a sub-module wb_fifo (DEPTH-entry synchronous FIFO, push/pop/full/empty/count).

Verification
REQ-030 ALU only: alu_valid, alu_da=3, alu_d=0x1234 one cycle -> next cycle write=1, DA=3, D=0x1234; following cycle write=0.
REQ-031 Load only: mem_da=5, mem_d=0xAA accepted at cycle t -> write=1, DA=5, D=0xAA at t+2.
REQ-032 Starvation: alu_valid held high with DA 1,2,3,4..., one load DA=9 buffered -> 3 ALU writes, then DA=9 write with alu_ready=0 that cycle, then ALU resumes.
REQ-033 Full: alu_valid held, 2 loads accepted -> mem_ready=0 from next cycle until first load issues; third load waits, never lost, order preserved.
REQ-034 Zero register: alu_da=31, alu_d=0xFFFF -> alu_ready=1, write stays 0; with WB_FORWARD_EN and SA=31, fwd_a_hit=0.
REQ-035 Reset mid-operation: 2 loads buffered, reset=0 one cycle -> write=0, DA=31, D=0, mem_ready=1 after release, no buffered load ever written.
